// File: rtl/self_trigger_window_capture_pkg.sv
// Shared widths and types for the trigger window capture stage of the
// pedestal recovery filter chain.
package pedestal_recov_pkg;

    localparam int SAMPLE_W = 16;
    localparam int TS_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    typedef struct packed {
        logic first;
        logic last;
        logic abort;
    } beat_flags_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] data;
        beat_flags_t         flags;
    } beat_t;

endpackage

// File: rtl/self_trigger_window_capture_if.sv
// Frame output stream: valid/ready beats with frame markers and the
// trigger timestamp as sideband.
interface self_trigger_window_capture_if;
    import pedestal_recov_pkg::*;

    logic [SAMPLE_W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_first;
    logic                out_last;
    logic                out_abort;
    logic [TS_W-1:0]     out_timestamp;

    modport master (
        output out_data, out_valid, out_first, out_last, out_abort, out_timestamp,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_first, out_last, out_abort, out_timestamp,
        output out_ready
    );

endinterface

// File: rtl/self_trigger_window_capture_ram.sv
// Simple dual-port sample ring buffer, one write and one synchronous read
// port, shaped for block RAM inference.
module trigger_window_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: neither the array nor the read register has a reset; a reset
    // would stop the tools from mapping this onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/self_trigger_window_capture.sv
// Captures a window of samples around each accepted trigger from a ring
// buffer and streams it out as one frame; triggers during dead time are counted.
module self_trigger_window_capture
    import pedestal_recov_pkg::*;
#(
    parameter int PRE_SAMPLES = 64,
    parameter int WINDOW      = 256,
    parameter int ADDR_W      = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic signed [SAMPLE_W-1:0]    x,
    input  logic                          trigger,
    input  logic [TS_W-1:0]               timestamp,
    self_trigger_window_capture_if.master st,
    output logic                          busy,
    output logic [15:0]                   dropped_count
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int REM_W  = $clog2(WINDOW + 1);
    localparam int FILL_W = $clog2(PRE_SAMPLES + 1);

    localparam logic [ADDR_W-1:0] PRE_OFFSET  = ADDR_W'(PRE_SAMPLES);
    localparam logic [ADDR_W-1:0] UNREAD_FULL = ADDR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(PRE_SAMPLES);
    localparam logic [REM_W-1:0]  REM_WINDOW  = REM_W'(WINDOW);

    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]   fill_q;
    logic [15:0]         dropped_q;
    state_e              state_q;
    logic [REM_W-1:0]    remain_q;
    logic                first_q, abort_q;
    logic [TS_W-1:0]     ts_q;

    logic                rd_pend_q;
    beat_flags_t         pend_flags_q;
    logic                out_valid_q, out_valid_d;
    beat_t               out_beat_q, out_beat_d;
    logic                skid_valid_q, skid_valid_d;
    beat_t               skid_beat_q, skid_beat_d;

    logic [SAMPLE_W-1:0] ram_rdata;
    beat_t               ram_beat;
    beat_flags_t         issue_flags;
    logic [ADDR_W-1:0]   unread;
    logic [1:0]          occupancy;
    logic                pop, credit_ok, in_stream, overrun, abort_now;
    logic                issue_read, issue_abort, accept_trig, drop_trig;

    assign pop         = out_valid_q && st.out_ready;
    assign unread      = wr_ptr_q - rd_ptr_q;
    assign in_stream   = (state_q == ST_STREAM);
    assign accept_trig = (state_q == ST_IDLE) && trigger && enable && (fill_q == FILL_FULL);
    assign drop_trig   = trigger && !accept_trig;

    // A read may only be issued if the output register plus skid buffer can
    // absorb it, counting the beat still in flight from the RAM.
    assign occupancy = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
    assign credit_ok = (occupancy - 2'(pop)) < 2'd2;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        overrun     = 1'b0;
        abort_now   = 1'b0;
        issue_abort = 1'b0;
        issue_read  = 1'b0;
        if (in_stream) begin
            overrun     = (remain_q != '0) && (unread == UNREAD_FULL);
            abort_now   = abort_q || overrun;
            issue_abort = abort_now && credit_ok;
            issue_read  = !abort_now && (remain_q != '0) && (unread != '0) && credit_ok;
        end
        issue_flags.first = first_q;
        issue_flags.last  = issue_abort || (remain_q == REM_W'(1));
        issue_flags.abort = issue_abort;
    end

    trigger_window_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk   (clk),
        .we    (enable),
        .waddr (wr_ptr_q),
        .wdata (x),
        .re    (issue_read),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples values from before the edge regardless of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            dropped_q <= '0;
        end else begin
            if (enable) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                if (fill_q != FILL_FULL) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end
            if (drop_trig && dropped_q != 16'hFFFF) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            remain_q <= '0;
            first_q  <= 1'b0;
            abort_q  <= 1'b0;
            ts_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_trig) begin
                        rd_ptr_q <= wr_ptr_q - PRE_OFFSET;
                        ts_q     <= timestamp;
                        remain_q <= REM_WINDOW;
                        first_q  <= 1'b1;
                        abort_q  <= 1'b0;
                        state_q  <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (issue_abort) begin
                        abort_q  <= 1'b0;
                        remain_q <= '0;
                        first_q  <= 1'b0;
                    end else if (abort_now) begin
                        abort_q  <= 1'b1;
                        remain_q <= '0;
                    end else if (issue_read) begin
                        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                        remain_q <= remain_q - REM_W'(1);
                        first_q  <= 1'b0;
                    end
                    if (pop && out_beat_q.flags.last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The abort beat rides the read pipeline without a RAM access; its data is stale.
    assign ram_beat = '{data: ram_rdata, flags: pend_flags_q};

    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = rd_pend_q;
                skid_beat_d  = ram_beat;
            end else if (rd_pend_q) begin
                out_valid_d = 1'b1;
                out_beat_d  = ram_beat;
            end else begin
                out_valid_d = 1'b0;
                out_beat_d  = '0;
            end
        end else if (rd_pend_q) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = ram_beat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q    <= 1'b0;
            pend_flags_q <= '0;
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
        end else begin
            rd_pend_q    <= issue_read || issue_abort;
            pend_flags_q <= issue_flags;
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
        end
    end

    assign st.out_valid     = out_valid_q;
    assign st.out_data      = out_beat_q.data;
    assign st.out_first     = out_beat_q.flags.first;
    assign st.out_last      = out_beat_q.flags.last;
    assign st.out_abort     = out_beat_q.flags.abort;
    assign st.out_timestamp = ts_q;
    assign busy             = (state_q != ST_IDLE);
    assign dropped_count    = dropped_q;

endmodule

// File: tb/tb_self_trigger_window_capture.sv
// Directed bench for the trigger window capture: ramp frames, dead time,
// overrun abort, randomised handshake and mid-frame reset.
module tb_self_trigger_window_capture;

    localparam int PRE = 64;
    localparam int WIN = 256;
    localparam int AW  = 9;
    localparam int REF_DEPTH = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] x;
    logic        trigger;
    logic [63:0] timestamp;
    logic        busy;
    logic [15:0] dropped_count;

    self_trigger_window_capture_if st_if ();

    self_trigger_window_capture #(
        .PRE_SAMPLES (PRE),
        .WINDOW      (WIN),
        .ADDR_W      (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .x             (x),
        .trigger       (trigger),
        .timestamp     (timestamp),
        .st            (st_if),
        .busy          (busy),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned sample_idx = 0;
    logic [15:0] ref_x [REF_DEPTH];
    bit          rand_x = 1'b0;
    bit          hold_pend = 1'b0;
    logic [15:0] hold_data;
    bit          got_last = 1'b0;
    bit          busy_seen = 1'b0;
    int unsigned trig_idx;
    logic [63:0] trig_ts;

    logic [15:0] bq_data [$];
    bit          bq_first [$];
    bit          bq_last [$];
    bit          bq_abort [$];
    logic [63:0] bq_ts [$];

    task automatic clear_beats();
        bq_data.delete();
        bq_first.delete();
        bq_last.delete();
        bq_abort.delete();
        bq_ts.delete();
        got_last = 1'b0;
    endtask

    // Records the handshake that the coming rising edge will complete,
    // checks hold stability, then advances to the next falling edge.
    task automatic tick();
        if (st_if.out_valid && st_if.out_ready) begin
            bq_data.push_back(st_if.out_data);
            bq_first.push_back(st_if.out_first);
            bq_last.push_back(st_if.out_last);
            bq_abort.push_back(st_if.out_abort);
            bq_ts.push_back(st_if.out_timestamp);
            if (st_if.out_last) got_last = 1'b1;
        end
        if (hold_pend) begin
            checks++;
            if (st_if.out_valid !== 1'b1 || st_if.out_data !== hold_data) begin
                errors++;
                $display("FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h",
                         st_if.out_valid, st_if.out_data, hold_data);
            end
        end
        hold_pend = st_if.out_valid && !st_if.out_ready;
        hold_data = st_if.out_data;
        if (busy) busy_seen = 1'b1;
        if (enable) begin
            ref_x[sample_idx % REF_DEPTH] = x;
            sample_idx++;
        end
        @(negedge clk);
        timestamp = timestamp + 64'd1;
    endtask

    task automatic cyc(input bit en, input bit trg, input bit rdy);
        enable = en;
        trigger = trg;
        st_if.out_ready = rdy;
        if (en) x = rand_x ? 16'($urandom) : 16'(sample_idx);
        if (trg) begin
            trig_idx = sample_idx;
            trig_ts  = timestamp;
        end
        tick();
    endtask

    task automatic drain_frame(input int budget, input int en_pct, input int rdy_pct,
                               output bit done);
        int n = 0;
        while (!got_last && n < budget) begin
            cyc($urandom_range(99) < en_pct, 1'b0, $urandom_range(99) < rdy_pct);
            n++;
        end
        done = got_last;
    endtask

    // Index of the first beat disagreeing with the reference frame, or -1.
    function automatic int frame_mismatch(input int unsigned start, input bit exp_abort,
                                          input logic [63:0] exp_ts);
        int  n = bq_data.size();
        bit  is_last;
        for (int i = 0; i < n; i++) begin
            is_last = (i == n - 1);
            if (!(exp_abort && is_last) && bq_data[i] !== ref_x[(start + i) % REF_DEPTH]) return i;
            if (bq_first[i] != (i == 0)) return i;
            if (bq_last[i] != is_last) return i;
            if (bq_abort[i] != (exp_abort && is_last)) return i;
            if (bq_ts[i] !== exp_ts) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        trigger = 1'b0;
        x = '0;
        timestamp = 64'h0123_4567_0000_0000;
        st_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (st_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b, required 0", st_if.out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %0b, required 0", busy);
        end
        checks++;
        if (dropped_count !== 16'd0) begin
            errors++; $display("FAIL reset_dropped: got %0d, required 0", dropped_count);
        end
        checks++;
        if ({st_if.out_first, st_if.out_last, st_if.out_abort} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b, required 000",
                               {st_if.out_first, st_if.out_last, st_if.out_abort});
        end
        checks++;
        if (st_if.out_data !== 16'd0 || st_if.out_timestamp !== 64'd0) begin
            errors++; $display("FAIL reset_data_ts: got %h/%h, required 0/0",
                               st_if.out_data, st_if.out_timestamp);
        end
        reset = 1'b0;
    endtask

    task automatic test_early_trigger();
        clear_beats();
        busy_seen = 1'b0;
        repeat (9) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (20) cyc(1'b1, 1'b0, 1'b1);
        checks++;
        if (dropped_count !== 16'd1) begin
            errors++; $display("FAIL early_dropped: got %0d, required 1", dropped_count);
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++; $display("FAIL early_busy: got busy seen %0b, required 0", busy_seen);
        end
        checks++;
        if (bq_data.size() !== 0) begin
            errors++; $display("FAIL early_beats: got %0d beats, required 0", bq_data.size());
        end
    endtask

    task automatic test_ramp_frame();
        bit done;
        int mm;
        clear_beats();
        while (sample_idx != 500) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL ramp_busy: got %0b, required 1", busy);
        end
        drain_frame(600, 100, 100, done);
        checks++;
        if (!done) begin
            errors++; $display("FAIL ramp_timeout: got no last beat, required one within 600 cycles");
        end
        checks++;
        if (bq_data.size() !== WIN) begin
            errors++; $display("FAIL ramp_len: got %0d, required %0d", bq_data.size(), WIN);
        end
        checks++;
        if (bq_data.size() == 0 || bq_data[0] !== 16'd436 || bq_data[$] !== 16'd691) begin
            errors++; $display("FAIL ramp_ends: got first/last data %0d/%0d, required 436/691",
                               bq_data.size() ? bq_data[0] : 16'hx, bq_data.size() ? bq_data[$] : 16'hx);
        end
        mm = frame_mismatch(436, 1'b0, trig_ts);
        checks++;
        if (mm != -1) begin
            errors++; $display("FAIL ramp_frame: first bad beat %0d, required -1", mm);
        end
        checks++;
        if (busy !== 1'b0 || dropped_count !== 16'd1) begin
            errors++; $display("FAIL ramp_after: got busy=%0b dropped=%0d, required 0/1",
                               busy, dropped_count);
        end
    endtask

    task automatic test_dead_time();
        bit done;
        int mm;
        int unsigned t0;
        logic [63:0] ts0;
        clear_beats();
        cyc(1'b1, 1'b1, 1'b1);
        t0 = trig_idx;
        ts0 = trig_ts;
        repeat (19) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        drain_frame(600, 100, 100, done);
        checks++;
        if (!done || dropped_count !== 16'd2) begin
            errors++; $display("FAIL dead_dropped: got done=%0b dropped=%0d, required 1/2",
                               done, dropped_count);
        end
        mm = frame_mismatch(t0 - PRE, 1'b0, ts0);
        checks++;
        if (bq_data.size() !== WIN || mm != -1) begin
            errors++; $display("FAIL dead_frame: got len %0d bad beat %0d, required %0d/-1",
                               bq_data.size(), mm, WIN);
        end
        // Trigger on the very cycle the FSM is back in idle.
        clear_beats();
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got busy %0b, required 1", busy);
        end
        drain_frame(600, 100, 100, done);
        mm = frame_mismatch(trig_idx - PRE, 1'b0, trig_ts);
        checks++;
        if (!done || bq_data.size() !== WIN || mm != -1 || dropped_count !== 16'd2) begin
            errors++; $display("FAIL b2b_frame: got done=%0b len=%0d bad=%0d dropped=%0d, required 1/%0d/-1/2",
                               done, bq_data.size(), mm, dropped_count, WIN);
        end
    endtask

    task automatic test_overrun();
        bit done;
        int mm;
        int unsigned t0;
        logic [63:0] ts0;
        clear_beats();
        cyc(1'b1, 1'b1, 1'b1);
        t0 = trig_idx;
        ts0 = trig_ts;
        repeat (30) cyc(1'b1, 1'b0, 1'b1);
        repeat (480) cyc(1'b1, 1'b0, 1'b0);
        drain_frame(400, 100, 100, done);
        checks++;
        if (!done || bq_data.size() < 2 || bq_data.size() >= WIN) begin
            errors++; $display("FAIL overrun_len: got done=%0b len=%0d, required 1 and 2..%0d",
                               done, bq_data.size(), WIN - 1);
        end
        checks++;
        if (bq_abort.size() == 0 || bq_abort[$] !== 1'b1 || bq_last[$] !== 1'b1) begin
            errors++; $display("FAIL overrun_abort: got abort/last on final beat %0b/%0b, required 1/1",
                               bq_abort.size() ? bq_abort[$] : 1'b0, bq_last.size() ? bq_last[$] : 1'b0);
        end
        mm = frame_mismatch(t0 - PRE, 1'b1, ts0);
        checks++;
        if (mm != -1) begin
            errors++; $display("FAIL overrun_frame: first bad beat %0d, required -1", mm);
        end
        clear_beats();
        repeat (5) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        drain_frame(600, 100, 100, done);
        mm = frame_mismatch(trig_idx - PRE, 1'b0, trig_ts);
        checks++;
        if (!done || bq_data.size() !== WIN || mm != -1) begin
            errors++; $display("FAIL overrun_recover: got done=%0b len=%0d bad=%0d, required 1/%0d/-1",
                               done, bq_data.size(), mm, WIN);
        end
    endtask

    task automatic test_random_handshake();
        bit done;
        int mm;
        rand_x = 1'b1;
        clear_beats();
        repeat (30) cyc($urandom_range(99) < 70, 1'b0, $urandom_range(99) < 50);
        cyc(1'b1, 1'b1, $urandom_range(99) < 50);
        drain_frame(3000, 70, 50, done);
        mm = frame_mismatch(trig_idx - PRE, 1'b0, trig_ts);
        checks++;
        if (!done || bq_data.size() !== WIN || mm != -1) begin
            errors++; $display("FAIL random_frame: got done=%0b len=%0d bad=%0d, required 1/%0d/-1",
                               done, bq_data.size(), mm, WIN);
        end
        rand_x = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit done;
        int mm;
        int unsigned base;
        clear_beats();
        cyc(1'b1, 1'b1, 1'b1);
        repeat (40) cyc(1'b1, 1'b0, 1'b1);
        checks++;
        if (st_if.out_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got valid %0b, required 1", st_if.out_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (st_if.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_async: got valid=%0b busy=%0b, required 0/0",
                               st_if.out_valid, busy);
        end
        enable = 1'b0;
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold_pend = 1'b0;
        clear_beats();
        checks++;
        if (dropped_count !== 16'd0) begin
            errors++; $display("FAIL midreset_dropped_clr: got %0d, required 0", dropped_count);
        end
        base = sample_idx;
        while (sample_idx != base + 63) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (dropped_count !== 16'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL midreset_fill: got dropped=%0d busy=%0b, required 1/1",
                               dropped_count, busy);
        end
        drain_frame(600, 100, 100, done);
        mm = frame_mismatch(base, 1'b0, trig_ts);
        checks++;
        if (!done || bq_data.size() !== WIN || mm != -1) begin
            errors++; $display("FAIL midreset_frame: got done=%0b len=%0d bad=%0d, required 1/%0d/-1",
                               done, bq_data.size(), mm, WIN);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_early_trigger();
        test_ramp_frame();
        test_dead_time();
        test_overrun();
        test_random_handshake();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
